// File: rtl/freq_meter_pkg.sv
// Shared types and widths for the frequency meter.
package freq_meter_pkg;

  localparam int FREQ_W = 20;
  localparam int CNT_W  = 26;

  localparam logic [FREQ_W-1:0] FREQ_MAX = '1;
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    GATE  = 2'd2
  } state_t;

  // Increment that sticks at the all-ones value instead of wrapping.
  function automatic logic [CNT_W-1:0] cnt_sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/freq_meter_sync_edge.sv
// Two-flop synchronizer for an asynchronous input plus a rising-edge
// detector on the synchronized value.
module sync_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  // Shift the input through the synchronizer and keep one cycle of history.
  always_ff @(posedge clk) begin
    if (!rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make each flop take the pre-edge value
      // of its predecessor, so the chain advances exactly one stage per clock.
      meta_q <= d;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign rise = sync_q & ~prev_q;

endmodule

// File: rtl/freq_meter.sv
// Gated frequency meter: after a start request it waits for the first edge of
// sig_in, then counts rising edges over GATE_CYCLES clocks and publishes the
// count on freq with a one-cycle freq_valid pulse.
// Optional build macro FREQ_METER_PERIOD_EN adds a period output holding the
// clk-cycle distance between the two most recent edges seen during the gate.
module freq_meter
  import freq_meter_pkg::*;
#(
  parameter int CLK_HZ      = 50000000,
  parameter int GATE_CYCLES = CLK_HZ
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sig_in,
  input  logic              start,
  output logic              busy,
  output logic [FREQ_W-1:0] freq,
  output logic              freq_valid,
  output logic              overflow
`ifdef FREQ_METER_PERIOD_EN
  ,
  output logic [CNT_W-1:0]  period
`endif
);

  // Value of the gate counter in the last cycle of a window.
  localparam logic [CNT_W-1:0] GATE_LAST = CNT_W'(GATE_CYCLES - 1);

  state_t              state;
  state_t              state_nxt;
  logic [CNT_W-1:0]    gate_cnt;
  logic [FREQ_W-1:0]   edge_cnt;
  logic [FREQ_W-1:0]   edge_nxt;
  logic                sat;
  logic                sat_nxt;
  logic                rise;
  logic                gate_last;
  logic                done;
  logic                timeout;

  sync_edge_detect u_sync (
    .clk  (clk),
    .rst  (rst),
    .d    (sig_in),
    .rise (rise)
  );

  assign gate_last = (gate_cnt == GATE_LAST);

  // Edge count including this cycle's edge, pinned at full scale.
  always_comb begin
    edge_nxt = edge_cnt;
    sat_nxt  = sat;
    if (rise) begin
      if (edge_cnt == FREQ_MAX) sat_nxt  = 1'b1;
      else                      edge_nxt = edge_cnt + FREQ_W'(1);
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state decode and per-state control strobes.
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves a
    // variable unassigned, which would otherwise infer a latch.
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    timeout   = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = ARMED;
      end
      ARMED: begin
        busy = 1'b1;
        if (rise) begin
          state_nxt = GATE;
        end else if (gate_last) begin
          state_nxt = IDLE;
          timeout   = 1'b1;
        end
      end
      GATE: begin
        busy = 1'b1;
        if (gate_last) begin
          state_nxt = IDLE;
          done      = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Gate/edge counters and the published result.
  always_ff @(posedge clk) begin
    if (!rst) begin
      gate_cnt   <= '0;
      edge_cnt   <= '0;
      sat        <= 1'b0;
      freq       <= '0;
      overflow   <= 1'b0;
      freq_valid <= 1'b0;
    end else begin
      freq_valid <= done | timeout;
      case (state)
        IDLE: begin
          gate_cnt <= '0;
        end
        ARMED: begin
          // The arming edge (t0) restarts the window and is not counted.
          if (rise) begin
            gate_cnt <= '0;
            edge_cnt <= '0;
            sat      <= 1'b0;
          end else begin
            gate_cnt <= gate_cnt + CNT_W'(1);
          end
        end
        GATE: begin
          gate_cnt <= gate_cnt + CNT_W'(1);
          edge_cnt <= edge_nxt;
          sat      <= sat_nxt;
        end
        default: gate_cnt <= '0;
      endcase
      if (done) begin
        freq     <= edge_nxt;
        overflow <= sat_nxt;
      end else if (timeout) begin
        freq     <= '0;
        overflow <= 1'b0;
      end
    end
  end

`ifdef FREQ_METER_PERIOD_EN
  logic [CNT_W-1:0] since_edge;

  // Cycles since the last detected edge; captured into period on gate edges.
  always_ff @(posedge clk) begin
    if (!rst) begin
      since_edge <= '0;
      period     <= '0;
    end else begin
      if (rise) since_edge <= CNT_W'(1);
      else      since_edge <= cnt_sat_inc(since_edge);
      if (rise && state == GATE) period <= since_edge;
    end
  end
`endif

endmodule

// File: tb/tb_freq_meter.sv
// Randomized scoreboard bench for freq_meter: a small meter (100-cycle gate)
// exercises the normal, timeout, reset and restart behaviour while a large
// meter (2100000-cycle gate) runs alongside to reach count saturation.
module tb_freq_meter;
  import freq_meter_pkg::*;

  localparam int G_A = 100;
  localparam int G_B = 2100000;

  typedef struct {
    logic [FREQ_W-1:0] freq;
    logic              ovf;
    logic              chk_period;
    logic [CNT_W-1:0]  period;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a = 1'b0, sig_a = 1'b0, start_a = 1'b0;
  logic busy_a, freq_valid_a, overflow_a;
  logic [FREQ_W-1:0] freq_a;
  logic rst_b = 1'b0, sig_b = 1'b0, start_b = 1'b0;
  logic busy_b, freq_valid_b, overflow_b;
  logic [FREQ_W-1:0] freq_b;
`ifdef FREQ_METER_PERIOD_EN
  logic [CNT_W-1:0] period_a, period_b;
`endif

  freq_meter #(.CLK_HZ(50000000), .GATE_CYCLES(G_A)) dut_a (
    .clk(clk), .rst(rst_a), .sig_in(sig_a), .start(start_a), .busy(busy_a),
    .freq(freq_a), .freq_valid(freq_valid_a), .overflow(overflow_a)
`ifdef FREQ_METER_PERIOD_EN
    , .period(period_a)
`endif
  );

  freq_meter #(.CLK_HZ(50000000), .GATE_CYCLES(G_B)) dut_b (
    .clk(clk), .rst(rst_b), .sig_in(sig_b), .start(start_b), .busy(busy_b),
    .freq(freq_b), .freq_valid(freq_valid_b), .overflow(overflow_b)
`ifdef FREQ_METER_PERIOD_EN
    , .period(period_b)
`endif
  );

  int   n_total = 0;
  int   n_pass  = 0;
  int   n_results_a = 0;
  exp_t exp_q[$];
  exp_t mon_e;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
  endtask

  // Reference: a periodic input of period p gives floor(g/p) edges inside the
  // window, clipped to the 20-bit range; period is p once any edge was gated.
  function automatic exp_t model(input int g, input int p);
    exp_t e;
    int   n;
    n = (p == 0) ? 0 : g / p;
    e.freq       = (n > int'(FREQ_MAX)) ? FREQ_MAX : FREQ_W'(n);
    e.ovf        = (n > int'(FREQ_MAX));
    e.chk_period = (n >= 1);
    e.period     = CNT_W'(p);
    return e;
  endfunction

  // Periodic stimulus generator for the small meter.
  logic gen_on = 1'b0;
  int   gen_p  = 10;
  initial forever begin
    if (gen_on) begin
      sig_a = 1'b1;
      repeat (gen_p / 2) @(negedge clk);
      sig_a = 1'b0;
      repeat (gen_p - gen_p / 2) @(negedge clk);
    end else begin
      sig_a = 1'b0;
      @(negedge clk);
    end
  end

  // Large meter input toggles every cycle (period 2).
  initial forever begin
    @(negedge clk);
    sig_b = ~sig_b;
  end

  // Monitor for the small meter: every result pops one expectation.
  always @(posedge clk) begin
    #1;
    if (freq_valid_a) begin
      n_results_a++;
      check("result_expected", exp_q.size() > 0, 1'b1);
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        check("freq", freq_a, mon_e.freq);
        check("overflow", overflow_a, mon_e.ovf);
        check("busy_at_valid", busy_a, 1'b0);
`ifdef FREQ_METER_PERIOD_EN
        if (mon_e.chk_period) check("period", period_a, mon_e.period);
`endif
      end
    end
  end

  task automatic quiet();
    gen_on = 1'b0;
    repeat (120) @(negedge clk);
  endtask

  task automatic pulse_start();
    @(negedge clk) start_a = 1'b1;
    @(negedge clk) start_a = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) @(posedge clk);
    repeat (2) @(posedge clk);
    check("drain", exp_q.size(), 0);
  endtask

  task automatic measure(input int p);
    quiet();
    gen_p = p;
    exp_q.push_back(model(G_A, p));
    pulse_start();
    gen_on = 1'b1;
    wait_drain(500);
  endtask

  task automatic run_a();
    int w;
    int base;
    int dir_p[6] = '{10, 7, 2, 50, 100, 101};

    // Directed periods, including exact-division and window-edge cases.
    foreach (dir_p[i]) measure(dir_p[i]);
    for (int i = 0; i < 8; i++) measure(int'($urandom_range(2, 40)));

    // No input edges: ARMED times out after G_A cycles with a zero result.
    quiet();
    exp_q.push_back(model(G_A, 0));
    @(negedge clk) start_a = 1'b1;
    @(posedge clk);
    #1 start_a = 1'b0;
    check("busy_armed", busy_a, 1'b1);
    w = 0;
    while (!freq_valid_a && w < 300) begin
      @(posedge clk);
      #1;
      w++;
    end
    check("timeout_latency", w, G_A);
    wait_drain(50);

    // Reset in the middle of a gate discards the measurement.
    measure(10);
    quiet();
    gen_p = 10;
    pulse_start();
    gen_on = 1'b1;
    repeat (60) @(negedge clk);
    check("busy_before_reset", busy_a, 1'b1);
    rst_a = 1'b0;
    @(negedge clk) rst_a = 1'b1;
    check("busy_after_reset", busy_a, 1'b0);
    check("freq_after_reset", freq_a, 0);
    check("valid_after_reset", freq_valid_a, 1'b0);
    base = n_results_a;
    repeat (250) @(negedge clk);
    check("no_result_after_reset", n_results_a - base, 0);
    check("freq_held_zero", freq_a, 0);

    // Starts while busy are ignored; a start in the result cycle is taken.
    quiet();
    gen_p = 8;
    base = n_results_a;
    exp_q.push_back(model(G_A, 8));
    pulse_start();
    gen_on = 1'b1;
    for (int i = 0; i < 5; i++) begin
      repeat (15) @(negedge clk);
      pulse_start();
    end
    w = 0;
    while (!freq_valid_a && w < 400) begin
      @(posedge clk);
      #1;
      w++;
    end
    check("first_result_seen", freq_valid_a, 1'b1);
    start_a = 1'b1;
    exp_q.push_back(model(G_A, 8));
    @(posedge clk);
    #1 start_a = 1'b0;
    check("restart_busy", busy_a, 1'b1);
    wait_drain(500);
    check("result_count", n_results_a - base, 2);
    gen_on = 1'b0;
  endtask

  task automatic run_b();
    int   w;
    exp_t e;
    e = model(G_B, 2);
    @(negedge clk) start_b = 1'b1;
    @(negedge clk) start_b = 1'b0;
    w = 0;
    while (!freq_valid_b && w < G_B + 200) begin
      @(posedge clk);
      #1;
      w++;
    end
    check("b_result_seen", freq_valid_b, 1'b1);
    check("b_freq", freq_b, e.freq);
    check("b_overflow", overflow_b, e.ovf);
    check("b_busy", busy_b, 1'b0);
`ifdef FREQ_METER_PERIOD_EN
    check("b_period", period_b, e.period);
`endif
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_busy", busy_a, 1'b0);
    check("rst_freq", freq_a, 0);
    check("rst_valid", freq_valid_a, 1'b0);
    check("rst_overflow", overflow_a, 1'b0);
`ifdef FREQ_METER_PERIOD_EN
    check("rst_period", period_a, 0);
`endif
    rst_a = 1'b1;
    rst_b = 1'b1;
    fork
      run_a();
      run_b();
    join
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
